if_id_stage_buffer: RTL
=======================

// Module: if_id_stage_buffer
// PURPOSE
//  Fetch-to-decode boundary register, directly downstream of the instruction-fetch stage.
//  Captures each fetched {instruction, PC+4} pair into a small in-order buffer.
//  Presents it to decode with a valid/ready handshake, absorbing decode stalls without dropping fetches.
//  Supports a synchronous flush for taken branches and jumps.
//  Exports the recovered PC (PC+4 minus 4) so decode/branch logic does not recompute it.
// PARAMETERS
//  XLEN    32            width of instruction, PC and PC+4 words
//  DEPTH   2             buffer entries; power of two, >= 2
//  NOP_INS 32'h00000013  word driven on out_ins when empty (addi x0,x0,0)
// PORTS
//  clk          in   1     rising-edge clock (the design's single clock)
//  rst_n        in   1     asynchronous, active-low reset
//  in_valid     in   1     fetch stage presents ins/PC+4 this cycle
//  in_ready     out  1     buffer can accept; high when count < DEPTH
//  in_ins       in   XLEN  fetched instruction word
//  in_pcp4      in   XLEN  PC+4 of the fetched instruction
//  flush        in   1     discard all held entries and any concurrent input
//  out_valid    out  1     head entry available to decode; high when count > 0
//  out_ready    in   1     decode consumes head this cycle
//  out_ins      out  XLEN  head instruction; NOP_INS when out_valid=0
//  out_pcp4     out  XLEN  head PC+4; 0 when out_valid=0
//  out_pc       out  XLEN  out_pcp4 - 4, modulo 2^XLEN; 0 when out_valid=0
//  out_misalign out  1     head PC+4 bits [1:0] != 0; 0 when out_valid=0
//  count        out  $clog2(DEPTH)+1  current occupancy
// BEHAVIOUR
//  - Reset (rst_n=0, async): count=0, pointers=0, out_valid=0, in_ready=1,
//    out_ins=NOP_INS, out_pcp4=0, out_pc=0, out_misalign=0. Storage contents are don't-care.
//  - push = in_valid & in_ready; pop = out_valid & out_ready; evaluated at each rising clk.
//  - Latency: an entry pushed at edge N is visible on out_* after edge N. No combinational
//    in->out pass-through. in_ready and out_valid derive only from registered count.
//  - Order: strict FIFO. Write pointer and read pointer wrap modulo DEPTH.
//  - Full (count=DEPTH): in_ready=0, so in_valid is ignored. Push and pop in the same cycle are
//    not possible when full; count drops to DEPTH-1 after a pop.
//  - Empty (count=0): out_valid=0, so out_ready is ignored. out_* show the idle values above.
//  - Simultaneous push and pop with 0 < count < DEPTH: count unchanged, both pointers advance.
//    This sustains full throughput of 1 instruction/cycle.
//  - flush=1 at an edge: count->0, rd_ptr<=wr_ptr. A concurrent push is discarded and a
//    concurrent pop is still reported to decode as taken. flush overrides push and pop for
//    occupancy. out_valid=0 in the following cycle.
//  - out_pc arithmetic: XLEN-bit subtract, wrap-around. in_pcp4=0 gives out_pc=32'hFFFFFFFC.
//  - Reset asserted mid-operation: all held entries are lost immediately (async).
//    The first push after deassertion lands in entry 0.
//  - Inputs are sampled only on push. in_ins and in_pcp4 may change freely while in_valid=0.
// STRUCTURE
//  - Shared package if_id_pkg:
//    - XLEN and NOP_INS constants.
//    - typedef if_id_entry_t {ins, pcp4}, shared with the decode-stage register.
//  - One sub-module: if_id_ptr_ctrl, containing wr_ptr, rd_ptr and count, plus push/pop/flush
//    arbitration. The top level holds the entry array, the head mux and the PC-4 subtractor.
// TESTING
//  - Reset then idle:
//    -> in_ready=1, out_valid=0, out_ins=32'h00000013, count=0.
//  - Push ins=32'h00A00093, pcp4=32'h84 with out_ready=0:
//    -> next cycle out_valid=1, out_ins=32'h00A00093, out_pc=32'h80, count=1.
//  - Hold out_ready=0 and push 3 entries (pcp4 0x84, 0x88, 0x8C):
//    -> in_ready=0 after 2nd push and 3rd is not accepted.
//    Then assert out_ready: pops 0x84, then 0x88, in order.
//  - Stream 11 consecutive fetches (pcp4 0x84..0xAC) with in_valid=out_ready=1:
//    -> one entry/cycle, count stays 1, outputs arrive in order with out_pc 0x80..0xA8.
//  - count=2, then assert flush together with in_valid=1:
//    -> next cycle count=0, out_valid=0, flushed input never appears on out_*.
//  - Push pcp4=0 then pcp4=32'h86:
//    -> out_pc=32'hFFFFFFFC with out_misalign=0, then out_pc=32'h82 with out_misalign=1.
//    Assert rst_n=0 mid-stream -> out_valid drops immediately, without waiting for clk.

Source files
------------

// File: rtl/if_id_pkg.sv
// Shared types and constants for the fetch/decode boundary.
package if_id_pkg;

    localparam int unsigned XLEN = 32;

    // Word shown to decode when nothing is held (addi x0,x0,0).
    localparam logic [XLEN-1:0] NOP_INS = 32'h0000_0013;

    // One fetched instruction with its PC+4, also reused by the decode-stage register.
    typedef struct packed {
        logic [XLEN-1:0] ins;
        logic [XLEN-1:0] pcp4;
    } if_id_entry_t;

endpackage

// File: rtl/if_id_ptr_ctrl.sv
// Occupancy bookkeeping for the IF/ID buffer: pointers, count and push/pop/flush arbitration.
module if_id_ptr_ctrl #(
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic                       out_ready,
    input  logic                       flush,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic                       wr_en,
    output logic [$clog2(DEPTH)-1:0]   wr_ptr,
    output logic [$clog2(DEPTH)-1:0]   rd_ptr,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push;
    logic             pop;

    // Handshake flags come only from the registered count, so no input reaches them.
    assign in_ready  = (count_q != CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // A flushed push must not land in storage.
    assign wr_en     = push & ~flush;

    assign wr_ptr    = wr_ptr_q;
    assign rd_ptr    = rd_ptr_q;
    assign count     = count_q;

    // Next-state arbitration; flush wins over push and pop for occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers; reset drops every held entry at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/if_id_stage_buffer.sv
// Fetch-to-decode boundary buffer: small in-order queue of {ins, PC+4} with valid/ready on both sides.
module if_id_stage_buffer
    import if_id_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [XLEN-1:0]         in_ins,
    input  logic [XLEN-1:0]         in_pcp4,
    input  logic                    flush,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [XLEN-1:0]         out_ins,
    output logic [XLEN-1:0]         out_pcp4,
    output logic [XLEN-1:0]         out_pc,
    output logic                    out_misalign,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    if_id_entry_t     mem_q [DEPTH];
    if_id_entry_t     head;
    logic             wr_en;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    if_id_ptr_ctrl #(
        .DEPTH (DEPTH)
    ) u_ptr_ctrl (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .out_ready (out_ready),
        .flush     (flush),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .wr_en     (wr_en),
        .wr_ptr    (wr_ptr),
        .rd_ptr    (rd_ptr),
        .count     (count)
    );

    // Entry storage; contents are meaningless until written, so no reset is needed.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr] <= '{ins: in_ins, pcp4: in_pcp4};
        end
    end

    assign head = mem_q[rd_ptr];

    // Head presentation with idle values when empty; out_pc is a wrapping PC+4 minus 4.
    always_comb begin
        out_ins      = NOP_INS;
        out_pcp4     = '0;
        out_pc       = '0;
        out_misalign = 1'b0;
        if (out_valid) begin
            out_ins      = head.ins;
            out_pcp4     = head.pcp4;
            out_pc       = head.pcp4 - XLEN'(4);
            out_misalign = |head.pcp4[1:0];
        end
    end

endmodule
